fwd_ctrl: RTL

Operand-forwarding and load-use hazard controller for the 8-bit, 32-register pipelined core. Tracks the destination register of the three instructions ahead of decode and generates the forwarding selects and immediate select for the register bank's A/B operand muxes. Also generates the one-cycle load-use stall and the `RW_dm` write address. Sits beside the register bank and is driven by the same decode-stage instruction word.

---
 rtl/fwd_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fwd_ctrl.sv
`default_nettype none
// fwd_ctrl: operand-forwarding select and load-use stall generator (Rev 1.0).
// Optional macro FWD_STATS_EN adds saturating fwd_cnt / stall_cnt counters.
module fwd_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic        wr_en_id,
  input  logic        load_id,
  input  logic        imm_id,
  output logic [1:0]  mux_sel_A,
  output logic [1:0]  mux_sel_B,
  output logic        imm_sel,
  output logic        stall,
  output logic [4:0]  RW_dm,
  output logic        we_dm
`ifdef FWD_STATS_EN
  ,
  output logic [15:0] fwd_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int FWD_DEPTH = 3;

  // Producer chain, index 0 = EX (youngest), 1 = DM, 2 = WB.
  logic [FWD_DEPTH-1:0] prod_valid;
  logic [FWD_DEPTH-1:0] prod_load;
  logic [4:0]           prod_rd [FWD_DEPTH];

  logic [4:0] rd_id;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic [1:0] sel_a_nxt;
  logic [1:0] sel_b_nxt;
  logic       unused_bits;

  assign rd_id = ins[14:10];
  assign src_a = ins[9:5];
  assign src_b = ins[4:0];

  // Opcode and the load flags of DM/WB carry no forwarding meaning here.
  assign unused_bits = ^{ins[19:15], prod_load[FWD_DEPTH-1:1]};

  assign stall = prod_valid[0] && prod_load[0] &&
                 ((prod_rd[0] == src_a) || (!imm_id && (prod_rd[0] == src_b)));

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_a_nxt = 2'b00;
    sel_b_nxt = 2'b00;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (prod_valid[i] && (prod_rd[i] == src_a)) sel_a_nxt = 2'(i + 1);
      if (prod_valid[i] && (prod_rd[i] == src_b)) sel_b_nxt = 2'(i + 1);
    end
    if (imm_id || stall) sel_b_nxt = 2'b00;
    if (stall)           sel_a_nxt = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_valid <= '0;
      prod_load  <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) prod_rd[i] <= 5'd0;
    end else begin
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        prod_valid[i] <= prod_valid[i-1];
        prod_load[i]  <= prod_load[i-1];
        prod_rd[i]    <= prod_rd[i-1];
      end
      if (stall) begin
        prod_valid[0] <= 1'b0;
        prod_load[0]  <= 1'b0;
        prod_rd[0]    <= 5'd0;
      end else begin
        prod_valid[0] <= wr_en_id;
        prod_load[0]  <= load_id;
        prod_rd[0]    <= rd_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
      imm_sel   <= 1'b0;
    end else begin
      mux_sel_A <= sel_a_nxt;
      mux_sel_B <= sel_b_nxt;
      imm_sel   <= imm_id && !stall;
    end
  end

  assign RW_dm = prod_rd[1];
  assign we_dm = prod_valid[1];

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (((sel_a_nxt != 2'b00) || (sel_b_nxt != 2'b00)) && (fwd_cnt != 16'hFFFF))
        fwd_cnt <= fwd_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
